tx_axis_frame_fifo: RTL

//   Store-and-forward AXI-Stream frame FIFO that sits directly upstream of the
//   MAC TX user port (feeds user_tx_axis_*). It buffers each frame from the

---
 rtl/tx_axis_frame_fifo_if.sv | 14 +
 rtl/tx_axis_frame_fifo.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/tx_axis_frame_fifo_if.sv
// tx_axis_frame_fifo_if: AXI-Stream bundle used for both the application side and the MAC side of the frame FIFO.
interface tx_axis_frame_fifo_if #(
    parameter int DW = 32,
    parameter int KW = DW / 8
);
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tvalid;
    logic          tlast;
    logic          tuser;
    logic          tready;
    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/tx_axis_frame_fifo.sv
// tx_axis_frame_fifo: store-and-forward AXIS frame FIFO feeding the MAC TX port; overflowing frames are dropped whole.
// Define TX_FIFO_TUSER_DROP_EN to also discard frames flagged bad by s_axis.tuser on their tlast beat.
module tx_axis_frame_fifo #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
    parameter int DEPTH           = 512,
    parameter int ADDR_WIDTH      = $clog2(DEPTH)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    tx_axis_frame_fifo_if.slave   s_axis,
    tx_axis_frame_fifo_if.master  m_axis,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic [7:0]            frames_stored,
    output logic [15:0]           drop_count
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int W  = 1 + AXIS_DATA_BYTES + AXIS_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_mem [DEPTH];
    logic [W-1:0]    r_ram_q;
    logic [W-1:0]    r_buf [2];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_commit_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [7:0]      r_fs;
    logic [15:0]     r_drop;
    logic [1:0]      r_bcnt;
    logic            r_head;
    logic            r_rd_valid;
    logic            w_beat;
    logic            w_full;
    logic            w_fs_full;
    logic            w_bad;
    logic            w_wr_en;
    logic            w_commit;
    logic            w_restore;
    logic            w_drop_inc;
    logic            w_fetch_last;
    logic            w_mvalid;
    logic            w_pop;
    logic            w_rd_en;
    logic [2:0]      w_occ;

    assign s_axis.tready = !sys_rst;
    assign w_beat        = s_axis.tvalid & s_axis.tready;
    assign w_full        = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
    assign w_fetch_last  = r_rd_valid & r_ram_q[W-1];
    // A fetch of a tlast word on the same edge frees the slot the commit needs.
    assign w_fs_full     = (r_fs == 8'hFF) && !w_fetch_last;
`ifdef TX_FIFO_TUSER_DROP_EN
    assign w_bad = s_axis.tuser;
`else
    assign w_bad = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_wr_en    = 1'b0;
        w_commit   = 1'b0;
        w_restore  = 1'b0;
        w_drop_inc = 1'b0;
        if (w_beat) begin
            if (r_state == DROP) begin
                w_drop_inc = s_axis.tlast;
                w_next     = s_axis.tlast ? IDLE : DROP;
            end else if (w_full || (s_axis.tlast && (w_bad || w_fs_full))) begin
                w_restore  = 1'b1;
                w_drop_inc = s_axis.tlast;
                w_next     = s_axis.tlast ? IDLE : DROP;
            end else begin
                w_wr_en  = 1'b1;
                w_commit = s_axis.tlast;
                w_next   = s_axis.tlast ? IDLE : WRITE;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        r_state <= sys_rst ? IDLE : w_next;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_fs         <= '0;
            r_drop       <= '0;
        end else begin
            r_wr_ptr <= w_restore ? r_commit_ptr : r_wr_ptr + PW'(w_wr_en);
            if (w_commit)
                r_commit_ptr <= r_wr_ptr + PW'(1);
            r_fs <= r_fs + {7'd0, w_commit} - {7'd0, w_fetch_last};
            if (w_drop_inc && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        if (w_rd_en)
            r_ram_q <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    end

    // Reads in flight count against the 2-entry output buffer so it never overruns.
    assign w_mvalid = r_bcnt != 2'd0;
    assign w_pop    = w_mvalid & m_axis.tready;
    assign w_occ    = {1'b0, r_bcnt} + {2'b0, r_rd_valid} - {2'b0, w_pop};
    assign w_rd_en  = (r_fs != 8'd0) && (r_rd_ptr != r_commit_ptr) && (w_occ < 3'd2);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_bcnt     <= '0;
            r_head     <= 1'b0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
        end else begin
            r_rd_ptr   <= r_rd_ptr + PW'(w_rd_en);
            r_rd_valid <= w_rd_en;
            if (r_rd_valid)
                r_buf[r_head ^ r_bcnt[0]] <= r_ram_q;
            r_bcnt <= r_bcnt + {1'b0, r_rd_valid} - {1'b0, w_pop};
            r_head <= r_head ^ w_pop;
        end
    end

    assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = r_buf[r_head];
    assign m_axis.tvalid = w_mvalid;
    assign m_axis.tuser  = 1'b0;
    assign fifo_level    = r_wr_ptr - r_rd_ptr;
    assign frames_stored = r_fs;
    assign drop_count    = r_drop;
endmodule
